// File: rtl/regfile_pkg.sv
// Shared register-file writeback definitions: default widths and the writeback payload.
package regfile_pkg;

    localparam int unsigned RF_WIDTH = 32;
    localparam int unsigned RF_ADDR  = 5;

    typedef struct packed {
        logic [RF_ADDR-1:0]  rd;
        logic [RF_WIDTH-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot writeback arbiter: round-robin when REGFILE_WB_RR_ARB_EN is defined,
// otherwise fixed priority with the lowest index winning and no state.
module rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
`ifdef REGFILE_WB_RR_ARB_EN
    input  logic            clk,
    input  logic            reset_n,
`endif
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant_c
);

    function automatic logic [NREQ-1:0] lowest_set(input logic [NREQ-1:0] v);
        logic [NREQ-1:0] res;
        logic            found;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (v[i] && !found) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return res;
    endfunction

`ifdef REGFILE_WB_RR_ARB_EN
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] above;
    logic [NREQ-1:0] masked;

    // Prefer requesters above the last winner, wrap to the lowest otherwise.
    always_comb begin
        above = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            above[i] = (i > 32'(ptr));
        end
        masked  = req & above;
        grant_c = (|masked) ? lowest_set(masked) : lowest_set(req);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= PW'(NREQ - 1);
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (grant_c[i]) begin
                    ptr <= PW'(i);
                end
            end
        end
    end
`else
    always_comb begin
        grant_c = lowest_set(req);
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the register file, with a pending-write scoreboard.
// Define REGFILE_WB_RR_ARB_EN for round-robin arbitration; default is fixed priority.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = RF_WIDTH,
    parameter int unsigned ADDR  = RF_ADDR,
    parameter int unsigned NREQ  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ADDR-1:0]  req_rd,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic                  rf_wr_en,
    output logic [ADDR-1:0]       rf_rd,
    output logic [WIDTH-1:0]      rf_wdata,
    input  logic                  sb_set,
    input  logic [ADDR-1:0]       sb_set_rd,
    input  logic [ADDR-1:0]       rs1,
    input  logic [ADDR-1:0]       rs2,
    output logic                  hazard1,
    output logic                  hazard2
);

    localparam int unsigned NSB = 2 ** ADDR;

    logic [NREQ-1:0]  arb_req;
    logic [NREQ-1:0]  grant;
    logic             transfer;
    logic [ADDR-1:0]  sel_rd;
    logic [WIDTH-1:0] sel_wdata;
    logic [NSB-1:0]   sb;
    logic [NSB-1:0]   sb_next;

    // Requests seen during reset are never granted.
    assign arb_req = reset_n ? req_valid : '0;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
`ifdef REGFILE_WB_RR_ARB_EN
        .clk     (clk),
        .reset_n (reset_n),
`endif
        .req     (arb_req),
        .grant_c (grant)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    always_comb begin
        sel_rd    = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd    = req_rd[i*ADDR +: ADDR];
                sel_wdata = req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // x0 writes are accepted but never reach the register file.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rf_wr_en <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wr_en <= transfer && (sel_rd != '0);
            if (transfer) begin
                rf_rd    <= sel_rd;
                rf_wdata <= sel_wdata;
            end
        end
    end

    // Set wins over a same-cycle clear; bit 0 is never pending.
    always_comb begin
        sb_next = '0;
        for (int unsigned i = 1; i < NSB; i++) begin
            sb_next[i] = (sb_set && (sb_set_rd == ADDR'(i)))
                       | (sb[i] && !(rf_wr_en && (rf_rd == ADDR'(i))));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    assign hazard1 = sb[rs1];
    assign hazard2 = sb[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (either arbitration mode).
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ADDR  = 5;
    localparam int unsigned NREQ  = 3;

    logic                  clk;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ADDR-1:0]  req_rd;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic                  rf_wr_en;
    logic [ADDR-1:0]       rf_rd;
    logic [WIDTH-1:0]      rf_wdata;
    logic                  sb_set;
    logic [ADDR-1:0]       sb_set_rd;
    logic [ADDR-1:0]       rs1;
    logic [ADDR-1:0]       rs2;
    logic                  hazard1;
    logic                  hazard2;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_arbiter #(.WIDTH(WIDTH), .ADDR(ADDR), .NREQ(NREQ)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_wdata (req_wdata),
        .rf_wr_en  (rf_wr_en),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .sb_set    (sb_set),
        .sb_set_rd (sb_set_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .hazard1   (hazard1),
        .hazard2   (hazard2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input wb_req_t r);
        req_rd[i*ADDR +: ADDR]    = r.rd;
        req_wdata[i*WIDTH +: WIDTH] = r.wdata;
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [NREQ-1:0] exp_grant [3];
    logic [ADDR-1:0] exp_rd    [3];
    logic [WIDTH-1:0] exp_data [3];

    initial begin
`ifdef REGFILE_WB_RR_ARB_EN
        exp_grant[0] = 3'b001; exp_grant[1] = 3'b010; exp_grant[2] = 3'b100;
        exp_rd[0] = 5'd1; exp_rd[1] = 5'd2; exp_rd[2] = 5'd3;
        exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h33;
`else
        exp_grant[0] = 3'b001; exp_grant[1] = 3'b001; exp_grant[2] = 3'b001;
        exp_rd[0] = 5'd1; exp_rd[1] = 5'd1; exp_rd[2] = 5'd1;
        exp_data[0] = 32'h11; exp_data[1] = 32'h11; exp_data[2] = 32'h11;
`endif

        reset_n   = 1'b0;
        req_valid = 3'b111;
        req_rd    = '0;
        req_wdata = '0;
        sb_set    = 1'b1;
        sb_set_rd = 5'd7;
        rs1       = 5'd7;
        rs2       = 5'd5;
        set_req(0, '{rd: 5'd1, wdata: 32'h11});
        set_req(1, '{rd: 5'd2, wdata: 32'h22});
        set_req(2, '{rd: 5'd3, wdata: 32'h33});

        // Reset held two cycles with everything requesting.
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_ready",   64'(req_ready), 64'(3'b000));
            check("rst_wr_en",   64'(rf_wr_en),  64'(1'b0));
            check("rst_hazard1", 64'(hazard1),   64'(1'b0));
            check("rst_hazard2", 64'(hazard2),   64'(1'b0));
        end
        check("rst_rf_rd",    64'(rf_rd),    64'(5'd0));
        check("rst_rf_wdata", 64'(rf_wdata), 64'(32'h0));

        reset_n   = 1'b1;
        sb_set    = 1'b0;
        req_valid = 3'b000;
        #1;
        check("idle_ready", 64'(req_ready), 64'(3'b000));
        check("idle_haz1",  64'(hazard1),   64'(1'b0));
        tick();
        check("idle_wr_en", 64'(rf_wr_en), 64'(1'b0));

        // Contention with all three requesting for three cycles.
        req_valid = 3'b111;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("cont_ready%0d", c), 64'(req_ready), 64'(exp_grant[c]));
            tick();
            check($sformatf("cont_wr_en%0d", c), 64'(rf_wr_en), 64'(1'b1));
            check($sformatf("cont_rd%0d", c),    64'(rf_rd),    64'(exp_rd[c]));
            check($sformatf("cont_data%0d", c),  64'(rf_wdata), 64'(exp_data[c]));
        end

        // Single requester.
        req_valid = 3'b010;
        set_req(1, '{rd: 5'd5, wdata: 32'hDEADBEEF});
        #1;
        check("single_ready", 64'(req_ready), 64'(3'b010));
        tick();
        req_valid = 3'b000;
        check("single_wr_en", 64'(rf_wr_en), 64'(1'b1));
        check("single_rd",    64'(rf_rd),    64'(5'd5));
        check("single_data",  64'(rf_wdata), 64'(32'hDEADBEEF));
        #1;
        check("single_after_ready", 64'(req_ready), 64'(3'b000));
        tick();
        check("single_after_wr_en", 64'(rf_wr_en), 64'(1'b0));

        // Write to x0 is accepted but suppressed.
        req_valid = 3'b001;
        set_req(0, '{rd: 5'd0, wdata: 32'h55});
        #1;
        check("x0_ready", 64'(req_ready), 64'(3'b001));
        tick();
        req_valid = 3'b000;
        check("x0_wr_en", 64'(rf_wr_en), 64'(1'b0));

        // Scoreboard set, then committed writeback clears it.
        rs1       = 5'd7;
        rs2       = 5'd0;
        sb_set    = 1'b1;
        sb_set_rd = 5'd7;
        #1;
        check("sb_no_bypass", 64'(hazard1), 64'(1'b0));
        tick();
        sb_set = 1'b0;
        check("sb_set_haz1", 64'(hazard1), 64'(1'b1));
        check("sb_x0_haz2",  64'(hazard2), 64'(1'b0));
        req_valid = 3'b100;
        set_req(2, '{rd: 5'd7, wdata: 32'h77});
        #1;
        check("sb_wb_ready", 64'(req_ready), 64'(3'b100));
        tick();
        req_valid = 3'b000;
        check("sb_wb_wr_en", 64'(rf_wr_en), 64'(1'b1));
        check("sb_wb_rd",    64'(rf_rd),    64'(5'd7));
        check("sb_wb_haz1",  64'(hazard1),  64'(1'b1));
        tick();
        check("sb_clear_haz1", 64'(hazard1), 64'(1'b0));

        // Set and clear of the same bit in one cycle: set wins.
        sb_set    = 1'b1;
        sb_set_rd = 5'd7;
        req_valid = 3'b100;
        tick();
        sb_set    = 1'b0;
        req_valid = 3'b000;
        check("coll_pre_haz1", 64'(hazard1), 64'(1'b1));
        check("coll_pre_wr_en", 64'(rf_wr_en), 64'(1'b1));
        sb_set = 1'b1;
        tick();
        sb_set = 1'b0;
        check("coll_haz1", 64'(hazard1), 64'(1'b1));
        rs2 = 5'd7;
        #1;
        check("coll_haz2", 64'(hazard2), 64'(1'b1));
        tick();
        check("coll_hold_haz1", 64'(hazard1), 64'(1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR, default 5, meaning register index width.
REQ-003 The block SHALL have parameter NREQ, default 3, meaning number of writeback requesters.
REQ-004 The block SHALL have port clk  input  1  clock; reset reset_n, synchronous, active-low; clock clk.
REQ-005 The block SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-006 The block SHALL have port req_valid  input  NREQ  per-requester write request.
REQ-007 The block SHALL have port req_ready  output  NREQ  per-requester grant/accept.
REQ-008 The block SHALL have port req_rd  input  NREQ x ADDR  per-requester destination index.
REQ-009 The block SHALL have port req_wdata  input  NREQ x WIDTH  per-requester write data.
REQ-010 The block SHALL have port rf_wr_en  output  1  register-file write enable.
REQ-011 The block SHALL have port rf_rd  output  ADDR  register-file write index.
REQ-012 The block SHALL have port rf_wdata  output  WIDTH  register-file write data.
REQ-013 The block SHALL have port sb_set  input  1  mark destination pending at issue.
REQ-014 The block SHALL have port sb_set_rd  input  ADDR  destination to mark pending.
REQ-015 The block SHALL have port rs1, rs2  input  ADDR each  source indices to check.
REQ-016 The block SHALL have port hazard1, hazard2  output  1 each  source has a pending write.

Function
REQ-017 The block SHALL grant at most one requester per cycle; req_ready is combinational from req_valid and arbitration state, one-hot or zero.
REQ-018 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; requesters hold valid, rd, wdata stable until transfer.
REQ-019 The winning rd/wdata SHALL be registered; rf_wr_en/rf_rd/rf_wdata valid exactly 1 cycle after transfer; one transfer accepted every cycle (no back-pressure from the register file).
REQ-020 A transfer with rd == 0 SHALL be accepted but produce rf_wr_en = 0 the next cycle and not touch the scoreboard.
REQ-021 The scoreboard SHALL hold 2**ADDR pending bits; bit 0 permanently 0.
REQ-022 sb_set with sb_set_rd != 0 SHALL set that bit at the clock edge.
REQ-023 A bit SHALL clear at the edge ending the cycle in which rf_wr_en = 1 with rf_rd equal to it.
REQ-024 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-025 hazard1/hazard2 SHALL be combinational: scoreboard bit of rs1/rs2, 0 for index 0; no same-cycle bypass of sb_set.
REQ-026 With no req_valid high, req_ready SHALL be 0 and arbitration state unchanged.

Reset
REQ-027 While reset_n = 0 at clk rising edge: rf_wr_en <= 0, rf_rd <= 0, rf_wdata <= 0, all scoreboard bits <= 0, round-robin pointer <= NREQ-1 (index 0 first).
REQ-028 req_ready SHALL be 0 while reset_n = 0; a request pending during reset is not accepted and must be re-presented.

Configuration
REQ-029 Macro REGFILE_WB_RR_ARB_EN defined: round-robin, search starts at last-granted index + 1, pointer updates only on transfer.
REQ-030 Macro REGFILE_WB_RR_ARB_EN undefined: fixed priority, lowest index wins, no pointer register.

Structure
REQ-031 Package regfile_pkg SHALL hold WIDTH/ADDR defaults and a wb_req_t typedef (rd, wdata); the block imports it.
REQ-032 Arbitration SHALL be a sub-module rr_arbiter (NREQ-wide, one-hot grant, priority mode per macro).

Verification
REQ-033 Reset: reset_n=0 two cycles with all req_valid=1 -> req_ready=0, rf_wr_en=0, hazard1=hazard2=0.
REQ-034 Single: req_valid=3'b010, rd=5, wdata=0xDEADBEEF -> req_ready=3'b010; next cycle rf_wr_en=1, rf_rd=5, rf_wdata=0xDEADBEEF.
REQ-035 Contention, RR macro on: req_valid=3'b111 held 3 cycles -> grants 001, 010, 100; macro off -> 001 all three cycles.
REQ-036 x0: rd=0 request -> accepted, next cycle rf_wr_en=0.
REQ-037 Scoreboard: sb_set rd=7; rs1=7 -> hazard1=1; writeback rd=7 commits -> hazard1=0 cycle after rf_wr_en.
REQ-038 Collision: sb_set rd=7 in same cycle as rf_wr_en rd=7 -> bit 7 remains set, hazard1=1.
